router_sync_n: RTL
==================

# router_sync_n

Parametrised write-steering and read-timeout controller for the router's N-output FIFO bank. It sits between the router FSM/register stage and the per-channel output FIFOs, and does four things:
- latches the destination address of each packet;
- steers the write enable to one FIFO;
- reports the addressed FIFO's full status back to the FSM;
- issues per-channel soft-reset pulses when a channel holds valid data that nobody reads within a programmable timeout.

It adds an address-valid flag and an illegal-address error output.

## Interface
Parameters:
- NUM_CH, 3: number of output channels, 1..8.
- ADDR_W, 2: width of the header address field; requires 2**ADDR_W >= NUM_CH.
- TIMEOUT, 30: consecutive unread-valid cycles before soft reset; range 2..255.

Ports (name, direction, width, meaning):
- clock, in, 1: rising-edge clock.
- resetn, in, 1: reset, synchronous, active-low.
- detect_add, in, 1: header byte present; capture data_in.
- data_in, in, ADDR_W: destination address field.
- write_enb_reg, in, 1: FSM requests a write to the addressed FIFO.
- empty, in, NUM_CH: per-FIFO empty flags.
- full, in, NUM_CH: per-FIFO full flags.
- read_enb, in, NUM_CH: per-channel read strobes from the sinks.
- write_enb, out, NUM_CH: one-hot (or zero) FIFO write enables; combinational.
- fifo_full, out, 1: full flag of the addressed FIFO; combinational.
- addr_valid, out, 1: a legal address is latched.
- addr_err, out, 1: one-cycle pulse when an illegal address is captured.
- vld_out, out, NUM_CH: equals ~empty; combinational.
- soft_reset, out, NUM_CH: per-channel one-cycle timeout pulses.

## Operation
**Address register**
- On a clock edge with detect_add=1:
  - addr <= data_in.
  - addr_valid <= (data_in < NUM_CH).
  - addr_err <= (data_in >= NUM_CH).
- On any other edge, addr_err <= 0, and addr and addr_valid hold.

**Write enable**
- write_enb = (write_enb_reg && addr_valid) ? (1 << addr) : 0.
- The value is computed from the registered addr. If detect_add and write_enb_reg are high in the same cycle, the previous address steers the write.
- With an illegal address, write_enb = 0 and the data is silently dropped.

**FIFO full**
- fifo_full = addr_valid ? full[addr] : 0.

**Timeout, per channel i**
- Counter cnt_i is $clog2(TIMEOUT) bits wide.
- When vld_out[i]=0 or read_enb[i]=1: cnt_i <= 0 and soft_reset[i] <= 0.
- Otherwise, if cnt_i == TIMEOUT-1: cnt_i <= 0 and soft_reset[i] <= 1.
- Otherwise: cnt_i <= cnt_i+1 and soft_reset[i] <= 0.
- If the channel stays valid and unread, it re-arms and pulses again every TIMEOUT cycles.
- Channels are fully independent. Simultaneous timeouts on several channels produce simultaneous pulses.

**Reset** (resetn=0 at an edge)
- addr=0, addr_valid=0, addr_err=0, all cnt_i=0, soft_reset=0.
- Combinational outputs therefore reset to write_enb=0 and fifo_full=0.
- vld_out follows empty regardless of reset.
- Reset asserted mid-count aborts any pending pulse.

## Timing
- write_enb, fifo_full and vld_out have zero latency from their inputs.
- addr_valid and addr_err update one cycle after detect_add.
- soft_reset[i] asserts at the rising edge following the TIMEOUT-th consecutive cycle with vld_out[i]=1 and read_enb[i]=0, counting from a counter value of 0. It lasts exactly one cycle.
- A read strobe on the same cycle that would reach terminal count wins: no pulse, and the counter clears.
- The FIFO is expected to flush on soft_reset. The resulting empty=1 holds the counter at 0.

## Structure
- Package router_pkg holds:
  - default constants ROUTER_NUM_CH=3, ROUTER_ADDR_W=2, ROUTER_TIMEOUT=30;
  - a function returning the counter width for a given TIMEOUT.
- One sub-module, router_sync_timer (ports: clock, resetn, vld, rd, soft_reset; parameter TIMEOUT). It is instantiated NUM_CH times via generate.
- The top level holds the address register, the write-enable decode and the full-flag mux.

## Test plan
- **Basic steer:** reset, detect_add with data_in=2, then write_enb_reg=1 → write_enb=3'b100 and addr_valid=1; full=3'b100 → fifo_full=1.
- **Illegal address:** data_in=3 with NUM_CH=3 → addr_err pulses 1 cycle, addr_valid=0; write_enb_reg=1 gives write_enb=0 and fifo_full=0.
- **Timeout:** empty[0]=0 held, no reads → soft_reset[0] pulses at exactly cycle 30 and again at cycle 60; channels 1 and 2 stay 0.
- **Read rescue:** read_enb[1]=1 on idle cycle 30 → no pulse on soft_reset[1]; next pulse 30 cycles after the read.
- **Simultaneous detect/write:** addr=0 latched; detect_add(data_in=1) and write_enb_reg in the same cycle → write_enb=3'b001 that cycle, 3'b010 the next.
- **Reset mid-count:** resetn low at idle cycle 20 → soft_reset stays 0, and a fresh full 30-cycle count is needed after release.

Source files
------------

// File: rtl/router_pkg.sv
// Shared constants and helpers for the router write-steering / timeout block.
package router_pkg;

  localparam int ROUTER_NUM_CH  = 3;
  localparam int ROUTER_ADDR_W  = 2;
  localparam int ROUTER_TIMEOUT = 30;

  // Width of a counter able to hold TIMEOUT-1 (never narrower than one bit).
  function automatic int timer_cnt_w(input int timeout);
    return ($clog2(timeout) < 1) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/router_sync_timer.sv
// Per-channel read-timeout counter: pulses soft_reset for one cycle when the
// channel has held valid data for TIMEOUT consecutive unread cycles.
module router_sync_timer
  import router_pkg::*;
#(
  parameter int TIMEOUT = ROUTER_TIMEOUT
) (
  input  logic clock,
  input  logic resetn,
  input  logic vld,
  input  logic rd,
  output logic soft_reset
);

  localparam int CNT_W = timer_cnt_w(TIMEOUT);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  // Count idle-valid cycles; a read or an empty FIFO clears, terminal count re-arms and pulses.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end else if (!vld || rd) begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end else if (cnt == TERM) begin
      cnt        <= '0;
      soft_reset <= 1'b1;
    end else begin
      cnt        <= cnt + CNT_W'(1);
      soft_reset <= 1'b0;
    end
  end

endmodule

// File: rtl/router_sync_n.sv
// Router synchroniser: latches the packet address, steers the FIFO write
// enable, muxes back the addressed full flag and runs per-channel timeouts.
module router_sync_n
  import router_pkg::*;
#(
  parameter int NUM_CH  = ROUTER_NUM_CH,
  parameter int ADDR_W  = ROUTER_ADDR_W,
  parameter int TIMEOUT = ROUTER_TIMEOUT
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              detect_add,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              write_enb_reg,
  input  logic [NUM_CH-1:0] empty,
  input  logic [NUM_CH-1:0] full,
  input  logic [NUM_CH-1:0] read_enb,
  output logic [NUM_CH-1:0] write_enb,
  output logic              fifo_full,
  output logic              addr_valid,
  output logic              addr_err,
  output logic [NUM_CH-1:0] vld_out,
  output logic [NUM_CH-1:0] soft_reset
);

  logic [ADDR_W-1:0] addr;
  logic              legal_in;

  assign legal_in = (32'(data_in) < 32'(NUM_CH));
  assign vld_out  = ~empty;

  // Capture the header address; addr_err is a single-cycle flag per capture.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      addr       <= '0;
      addr_valid <= 1'b0;
      addr_err   <= 1'b0;
    end else if (detect_add) begin
      addr       <= data_in;
      addr_valid <= legal_in;
      addr_err   <= ~legal_in;
    end else begin
      addr_err   <= 1'b0;
    end
  end

  // Steer the write to the latched channel; illegal addresses drop the write.
  always_comb begin
    write_enb = '0;
    fifo_full = 1'b0;
    if (addr_valid) begin
      fifo_full = full[addr];
      if (write_enb_reg) write_enb[addr] = 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_timer
    router_sync_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clock      (clock),
      .resetn     (resetn),
      .vld        (vld_out[i]),
      .rd         (read_enb[i]),
      .soft_reset (soft_reset[i])
    );
  end

endmodule
